// File: rtl/exec_sequencer.sv
// Instruction execute sequencer: fetch/execute control FSM with a multi-cycle
// multiplier wait and a push-button release for the WAIT instruction.
package opcodes;
  typedef enum logic [2:0] {
    NOOP  = 3'd0,
    STSW  = 3'd1,
    LEDS  = 3'd2,
    PASSA = 3'd3,
    ADD   = 3'd4,
    STACC = 3'd5,
    MULT  = 3'd6,
    WAIT  = 3'd7
  } opcodes_t;

  typedef enum logic [1:0] {
    ALU_NOOP = 2'd0,
    ALU_A    = 2'd1,
    ALU_ADD  = 2'd2,
    ALU_MULT = 2'd3
  } alu_functions_t;
endpackage

module exec_sequencer #(
  parameter int unsigned MULT_CYCLES = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Run,
  input  opcodes::opcodes_t       OpCode,
  input  logic                    Button,
  output logic                    InstrLoad,
  output logic                    PcIncr,
  output logic                    RegWe,
  output logic                    WDataSel,
  output logic                    AccStore,
  output logic                    LedsWe,
  output opcodes::alu_functions_t AluOp,
  output logic                    Busy
);
  import opcodes::*;

  typedef enum logic [1:0] {FETCH, EXEC, MULWAIT, BTNWAIT} state_t;

  // EXEC is the first multiply cycle, so MULWAIT runs MULT_CYCLES-1 more.
  localparam logic [3:0] MulLoad = (MULT_CYCLES > 1) ? 4'(MULT_CYCLES - 2) : '0;

  state_t     state, stateNext;
  opcodes_t   ir;
  logic [3:0] cnt, cntNext;
  logic       sync1, sync2, prev;
  logic       btnEdge;

  assign btnEdge = sync2 & ~prev;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= FETCH;
      ir    <= NOOP;
      cnt   <= '0;
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      sync1 <= Button;
      sync2 <= sync1;
      prev  <= sync2;
      if (InstrLoad) ir <= OpCode;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    InstrLoad = 1'b0;
    PcIncr    = 1'b0;
    RegWe     = 1'b0;
    WDataSel  = 1'b0;
    AccStore  = 1'b0;
    LedsWe    = 1'b0;
    AluOp     = ALU_NOOP;
    Busy      = 1'b0;

    case (state)
      FETCH: begin
        if (Run) begin
          InstrLoad = 1'b1;
          stateNext = EXEC;
        end
      end
      EXEC: begin
        Busy = 1'b1;
        case (ir)
          NOOP: begin
            PcIncr    = 1'b1;
            stateNext = FETCH;
          end
          STSW: begin
            RegWe     = 1'b1;
            WDataSel  = 1'b1;
            PcIncr    = 1'b1;
            stateNext = FETCH;
          end
          LEDS: begin
            LedsWe    = 1'b1;
            PcIncr    = 1'b1;
            stateNext = FETCH;
          end
          PASSA: begin
            AluOp     = ALU_A;
            AccStore  = 1'b1;
            PcIncr    = 1'b1;
            stateNext = FETCH;
          end
          ADD: begin
            AluOp     = ALU_ADD;
            AccStore  = 1'b1;
            PcIncr    = 1'b1;
            stateNext = FETCH;
          end
          STACC: begin
            RegWe     = 1'b1;
            PcIncr    = 1'b1;
            stateNext = FETCH;
          end
          MULT: begin
            AluOp = ALU_MULT;
            if (MULT_CYCLES == 1) begin
              AccStore  = 1'b1;
              PcIncr    = 1'b1;
              stateNext = FETCH;
            end else begin
              cntNext   = MulLoad;
              stateNext = MULWAIT;
            end
          end
          WAIT: begin
            stateNext = BTNWAIT;
          end
        endcase
      end
      MULWAIT: begin
        Busy  = 1'b1;
        AluOp = ALU_MULT;
        if (cnt == 4'd0) begin
          AccStore  = 1'b1;
          PcIncr    = 1'b1;
          stateNext = FETCH;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      BTNWAIT: begin
        Busy = 1'b1;
        if (btnEdge) begin
          PcIncr    = 1'b1;
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase

    // Outputs are quiet during reset even though state still holds its old value.
    if (Reset) begin
      InstrLoad = 1'b0;
      PcIncr    = 1'b0;
      RegWe     = 1'b0;
      WDataSel  = 1'b0;
      AccStore  = 1'b0;
      LedsWe    = 1'b0;
      AluOp     = ALU_NOOP;
      Busy      = 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: per-cycle expected output vectors queued by the
// driver and compared on the falling edge, plus a random-stream invariant run.
module tb_exec_sequencer;
  import opcodes::*;

  typedef struct packed {
    logic       il, pc, rw, ws, as, lw;
    logic [1:0] alu;
    logic       busy;
  } outs_t;

  typedef struct {
    string nm;
    outs_t e;
  } sb_t;

  typedef struct {
    opcodes_t op;
    outs_t    exe;
    string    nm;
  } vec_t;

  logic           Clock = 1'b0;
  logic           Reset = 1'b1;
  logic           Run = 1'b0;
  logic           Button = 1'b0;
  opcodes_t       OpCode = NOOP;
  logic           InstrLoad, PcIncr, RegWe, WDataSel, AccStore, LedsWe, Busy;
  alu_functions_t AluOp;

  exec_sequencer #(.MULT_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .OpCode(OpCode), .Button(Button),
    .InstrLoad(InstrLoad), .PcIncr(PcIncr), .RegWe(RegWe), .WDataSel(WDataSel),
    .AccStore(AccStore), .LedsWe(LedsWe), .AluOp(AluOp), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int    checks = 0;
  int    failures = 0;
  sb_t   sbQ[$];
  outs_t act;

  assign act = {InstrLoad, PcIncr, RegWe, WDataSel, AccStore, LedsWe, AluOp, Busy};

  function automatic outs_t mk(logic il, logic pc, logic rw, logic ws, logic as,
                               logic lw, logic [1:0] alu, logic busy);
    mk = {il, pc, rw, ws, as, lw, alu, busy};
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", nm, a, e);
    end
  endtask

  always @(negedge Clock) begin
    sb_t s;
    if (sbQ.size() > 0) begin
      s = sbQ.pop_front();
      checks++;
      if (act !== s.e) begin
        failures++;
        $display("FAIL %s act=%b exp=%b (il pc rw ws as lw alu busy)", s.nm, act, s.e);
      end
    end
  end

  // Drive one cycle's inputs and queue the outputs expected during that cycle.
  task automatic cyc(input logic r, input logic rs, input opcodes_t op,
                     input outs_t e, input string nm);
    sb_t s;
    Run    = r;
    Reset  = rs;
    OpCode = op;
    s.nm   = nm;
    s.e    = e;
    sbQ.push_back(s);
    @(posedge Clock);
    #1;
  endtask

  outs_t IDLE, FLD, BSY, MULB, MULD;
  vec_t  tbl[6];
  int    nLoad, nPc, nHot;

  initial begin
    IDLE = '0;
    FLD  = mk(1, 0, 0, 0, 0, 0, ALU_NOOP, 0);
    BSY  = mk(0, 0, 0, 0, 0, 0, ALU_NOOP, 1);
    MULB = mk(0, 0, 0, 0, 0, 0, ALU_MULT, 1);
    MULD = mk(0, 1, 0, 0, 1, 0, ALU_MULT, 1);
    tbl[0] = '{NOOP,  mk(0, 1, 0, 0, 0, 0, ALU_NOOP, 1), "noop"};
    tbl[1] = '{STSW,  mk(0, 1, 1, 1, 0, 0, ALU_NOOP, 1), "stsw"};
    tbl[2] = '{LEDS,  mk(0, 1, 0, 0, 0, 1, ALU_NOOP, 1), "leds"};
    tbl[3] = '{PASSA, mk(0, 1, 0, 0, 1, 0, ALU_A,    1), "passa"};
    tbl[4] = '{ADD,   mk(0, 1, 0, 0, 1, 0, ALU_ADD,  1), "add"};
    tbl[5] = '{STACC, mk(0, 1, 1, 0, 0, 0, ALU_NOOP, 1), "stacc"};

    @(posedge Clock);
    #1;
    cyc(1, 1, ADD, IDLE, "reset_0");
    cyc(1, 1, ADD, IDLE, "reset_1");

    cyc(1, 0, ADD,  FLD,        "first_fetch");
    cyc(1, 0, NOOP, tbl[4].exe, "first_add_exec");
    cyc(1, 0, LEDS, FLD,        "second_fetch");
    cyc(0, 0, NOOP, tbl[2].exe, "second_leds_exec");

    // Run low and a garbage opcode during EXEC must not change the instruction.
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, tbl[i].op, FLD, {tbl[i].nm, "_fetch"});
      cyc(0, 0, WAIT, tbl[i].exe, {tbl[i].nm, "_exec"});
    end

    cyc(1, 0, MULT, FLD, "mult_fetch");
    for (int i = 0; i < 3; i++) cyc(0, 0, ADD, MULB, "mult_busy");
    cyc(0, 0, NOOP, MULD, "mult_done");
    cyc(0, 0, NOOP, IDLE, "mult_after");

    for (int i = 0; i < 5; i++) cyc(0, 0, STSW, IDLE, "run_hold");
    cyc(1, 0, STSW, FLD,        "stsw_fetch");
    cyc(0, 0, NOOP, tbl[1].exe, "stsw_exec");

    // Button rises while in FETCH; that edge must be dropped.
    Button = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, NOOP, IDLE, "btn_pre_idle");
    cyc(1, 0, WAIT, FLD, "wait_fetch");
    cyc(0, 0, NOOP, BSY, "wait_exec");
    for (int i = 0; i < 4; i++) cyc(0, 0, NOOP, BSY, "wait_held_high");
    Button = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, NOOP, BSY, "wait_btn_low");
    Button = 1'b1;
    cyc(0, 0, NOOP, BSY, "wait_sync1");
    cyc(0, 0, NOOP, BSY, "wait_sync2");
    cyc(0, 0, NOOP, mk(0, 1, 0, 0, 0, 0, ALU_NOOP, 1), "wait_release");
    cyc(0, 0, NOOP, IDLE, "wait_done");
    cyc(0, 0, NOOP, IDLE, "wait_no_second");

    cyc(1, 0, MULT, FLD,  "rmul_fetch");
    cyc(0, 0, NOOP, MULB, "rmul_exec");
    cyc(0, 0, NOOP, MULB, "rmul_cnt2");
    cyc(0, 1, NOOP, IDLE, "rmul_reset_cnt1");
    cyc(0, 0, NOOP, IDLE, "rmul_after");
    cyc(1, 0, PASSA, FLD, "rmul_refetch");
    cyc(0, 0, NOOP, tbl[3].exe, "rmul_passa");

    Button = 1'b0;
    cyc(1, 0, WAIT, FLD, "rbtn_fetch");
    cyc(0, 0, NOOP, BSY, "rbtn_exec");
    cyc(0, 0, NOOP, BSY, "rbtn_wait");
    cyc(0, 1, NOOP, IDLE, "rbtn_reset");
    cyc(0, 0, NOOP, IDLE, "rbtn_after");
    cyc(1, 0, NOOP, FLD, "rbtn_refetch");
    cyc(0, 0, NOOP, tbl[0].exe, "rbtn_noop");

    nLoad = 0;
    nPc   = 0;
    nHot  = 0;
    for (int c = 0; c < 6000 && nLoad < 1000; c++) begin
      Run    = 1'b1;
      OpCode = opcodes_t'($urandom_range(0, 6));
      @(negedge Clock);
      if (InstrLoad) nLoad++;
      if (PcIncr) nPc++;
      if ((32'(RegWe) + 32'(AccStore) + 32'(LedsWe)) > 1) nHot++;
      @(posedge Clock);
      #1;
    end
    Run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      if (PcIncr) nPc++;
      if ((32'(RegWe) + 32'(AccStore) + 32'(LedsWe)) > 1) nHot++;
      if (!Busy) break;
      @(posedge Clock);
      #1;
    end
    chk("rand_busy_drained", int'(Busy), 0);
    chk("rand_load_count", nLoad, 1000);
    chk("rand_pc_eq_load", nPc, nLoad);
    chk("rand_onehot_viol", nHot, 0);

    @(posedge Clock);
    #1;
    chk("scoreboard_empty", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
